// File: rtl/result_packer_pkg.sv
// result_packer_pkg: shared defaults, bank-state enum and count-width helper.
package result_packer_pkg;
   localparam int RES_WIDTH_DEF = 16;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/result_packer_if.sv
// result_packer_if: ALU result stream in, packed batch handshake out.
interface result_packer_if
   import result_packer_pkg::*;
#(
   parameter int NUM = 100,
   parameter int RES_WIDTH = RES_WIDTH_DEF
);
   logic done_i;
   logic [RES_WIDTH-1:0] res_i;
   logic flush_i;
   logic batch_valid_o;
   logic batch_ready_i;
   logic [NUM*RES_WIDTH-1:0] batch_data_o;
   logic [cnt_w(NUM)-1:0] batch_cnt_o;
   logic [15:0] drop_cnt_o;
   modport master (
      output done_i, res_i, flush_i, batch_ready_i,
      input batch_valid_o, batch_data_o, batch_cnt_o, drop_cnt_o
   );
   modport slave (
      input done_i, res_i, flush_i, batch_ready_i,
      output batch_valid_o, batch_data_o, batch_cnt_o, drop_cnt_o
   );
endinterface

// File: rtl/result_bank.sv
// result_bank: NUM x RES_WIDTH storage with one write port and a packed read port.
module result_bank #(
   parameter int NUM = 100,
   parameter int RES_WIDTH = 16,
   parameter int AW = $clog2(NUM)
) (
   input logic clk_i,
   input logic we,
   input logic [AW-1:0] waddr,
   input logic [RES_WIDTH-1:0] wdata,
   output logic [NUM*RES_WIDTH-1:0] rdata
);
   logic [RES_WIDTH-1:0] mem [NUM];
   always_ff @(posedge clk_i)
      if (we) mem[waddr] <= wdata;
   for (genvar i = 0; i < NUM; i++) begin : g_rd
      assign rdata[i*RES_WIDTH +: RES_WIDTH] = mem[i];
   end
endmodule

// File: rtl/result_packer.sv
// result_packer: ping-pong batcher of ALU results for a batch consumer.
// Define RESULT_PACKER_DROP_CNT_EN to build the saturating drop counter.
module result_packer
   import result_packer_pkg::*;
#(
   parameter int NUM = 100,
   parameter int RES_WIDTH = RES_WIDTH_DEF
) (
   input logic clk_i,
   input logic reset_i,
   result_packer_if.slave bus
);
   localparam int CW = cnt_w(NUM);
   localparam int AW = $clog2(NUM);
   bank_state_e st_q [2], st_d [2];
   logic [CW-1:0] cnt_q [2], cnt_d [2];
   logic [CW-1:0] idx_q, idx_d, idx_inc;
   logic wr_q, wr_d, rd_q, rd_d, valid_q, valid_d;
   logic wfull, wr_en, close, hs;
   logic [NUM*RES_WIDTH-1:0] data [2];
   // A FULL write bank means both banks are FULL, so the result is dropped.
   always_comb begin
      wfull = st_q[wr_q] == FULL;
      wr_en = bus.done_i && !wfull;
      idx_inc = idx_q + CW'(wr_en);
      close = (wr_en && idx_inc == CW'(NUM)) || (bus.flush_i && idx_inc != '0);
      hs = valid_q && bus.batch_ready_i;
      st_d = st_q;
      cnt_d = cnt_q;
      wr_d = close ? !wr_q : wr_q;
      idx_d = close ? '0 : idx_inc;
      if (close) begin
         st_d[wr_q] = FULL;
         cnt_d[wr_q] = idx_inc;
      end else if (wr_en) st_d[wr_q] = FILLING;
      if (hs) st_d[rd_q] = EMPTY;
      rd_d = hs ? !rd_q : rd_q;
      valid_d = st_d[rd_d] == FULL;
   end
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         st_q <= '{EMPTY, EMPTY};
         cnt_q <= '{'0, '0};
         idx_q <= '0;
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         st_q <= st_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         valid_q <= valid_d;
      end
   for (genvar b = 0; b < 2; b++) begin : g_bank
      result_bank #(.NUM(NUM), .RES_WIDTH(RES_WIDTH), .AW(AW)) u_bank (
         .clk_i(clk_i),
         .we(wr_en && wr_q == 1'(b)),
         .waddr(idx_q[AW-1:0]),
         .wdata(bus.res_i),
         .rdata(data[b])
      );
   end
   assign bus.batch_valid_o = valid_q;
   assign bus.batch_data_o = data[rd_q];
   assign bus.batch_cnt_o = cnt_q[rd_q];
`ifdef RESULT_PACKER_DROP_CNT_EN
   logic [15:0] drop_q;
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) drop_q <= '0;
      else if (bus.done_i && wfull && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
   assign bus.drop_cnt_o = drop_q;
`else
   assign bus.drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: scoreboard bench for result_packer at NUM=4, RES_WIDTH=16.
module tb_result_packer;
   typedef struct packed {
      logic [2:0] cnt;
      logic [63:0] data;
   } batch_t;
   logic clk_i = 1'b0;
   logic reset_i = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   batch_t exp_q [$];
   batch_t e;
`ifdef RESULT_PACKER_DROP_CNT_EN
   localparam logic [15:0] EXP_DROP = 16'd1;
`else
   localparam logic [15:0] EXP_DROP = 16'd0;
`endif
   result_packer_if #(.NUM(4), .RES_WIDTH(16)) bus ();
   result_packer #(.NUM(4), .RES_WIDTH(16)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));
   always #5 clk_i = !clk_i;

   task automatic test_reset();
      bus.done_i = 0; bus.res_i = '0; bus.flush_i = 0; bus.batch_ready_i = 0;
      reset_i = 0;
      @(negedge clk_i);
      n_checks++; if (bus.batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.batch_valid_o); end
      n_checks++; if (bus.batch_cnt_o !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.batch_cnt_o); end
      n_checks++; if (bus.drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt_o); end
      reset_i = 1;
   endtask

   task automatic test_full_batch();
      bus.batch_ready_i = 1;
      e = '0; e.cnt = 3'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         n_checks++; if (bus.batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b want 0 at write %0d", bus.batch_valid_o, i); end
         bus.done_i = 1; bus.res_i = 16'(i + 1);
         e.data[i*16 +: 16] = 16'(i + 1);
      end
      exp_q.push_back(e);
      @(negedge clk_i);
      bus.done_i = 0;
      n_checks++; if (bus.batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", bus.batch_valid_o); end
      e = exp_q.pop_front();
      n_checks++; if (bus.batch_cnt_o !== e.cnt) begin n_fail++; $display("FAIL full_cnt: got %0d want %0d", bus.batch_cnt_o, e.cnt); end
      n_checks++; if (bus.batch_data_o !== e.data) begin n_fail++; $display("FAIL full_data: got %h want %h", bus.batch_data_o, e.data); end
      @(negedge clk_i);
      n_checks++; if (bus.batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_after_hs: got %b want 0", bus.batch_valid_o); end
   endtask

   task automatic test_flush();
      bus.batch_ready_i = 1;
      e = '0; e.cnt = 3'd2; e.data[15:0] = 16'hAAAA; e.data[31:16] = 16'h5555;
      @(negedge clk_i); bus.done_i = 1; bus.res_i = 16'hAAAA;
      @(negedge clk_i); bus.res_i = 16'h5555;
      @(negedge clk_i); bus.done_i = 0; bus.flush_i = 1;
      exp_q.push_back(e);
      @(negedge clk_i); bus.flush_i = 0;
      n_checks++; if (bus.batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b want 1", bus.batch_valid_o); end
      e = exp_q.pop_front();
      n_checks++; if (bus.batch_cnt_o !== e.cnt) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", bus.batch_cnt_o, e.cnt); end
      for (int k = 0; k < int'(e.cnt); k++) begin
         n_checks++; if (bus.batch_data_o[k*16 +: 16] !== e.data[k*16 +: 16]) begin n_fail++; $display("FAIL flush_entry%0d: got %h want %h", k, bus.batch_data_o[k*16 +: 16], e.data[k*16 +: 16]); end
      end
      @(negedge clk_i); bus.flush_i = 1;
      @(negedge clk_i); bus.flush_i = 0;
      for (int k = 0; k < 2; k++) begin
         n_checks++; if (bus.batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid: got %b want 0", bus.batch_valid_o); end
         @(negedge clk_i);
      end
   endtask

   task automatic test_overflow();
      batch_t b1, b2;
      bus.batch_ready_i = 0;
      b1 = '0; b1.cnt = 3'd4; b2 = '0; b2.cnt = 3'd4;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_i); bus.done_i = 1; bus.res_i = 16'h0010 + 16'(i);
         if (i < 4) b1.data[i*16 +: 16] = 16'h0010 + 16'(i);
         else if (i < 8) b2.data[(i-4)*16 +: 16] = 16'h0010 + 16'(i);
      end
      exp_q.push_back(b1);
      exp_q.push_back(b2);
      @(negedge clk_i); bus.done_i = 0;
      n_checks++; if (bus.batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", bus.batch_valid_o); end
      n_checks++; if (bus.drop_cnt_o !== EXP_DROP) begin n_fail++; $display("FAIL ovf_drop: got %0d want %0d", bus.drop_cnt_o, EXP_DROP); end
      @(negedge clk_i);
      e = exp_q.pop_front();
      n_checks++; if (bus.batch_cnt_o !== e.cnt) begin n_fail++; $display("FAIL ovf_cnt1: got %0d want %0d", bus.batch_cnt_o, e.cnt); end
      n_checks++; if (bus.batch_data_o !== e.data) begin n_fail++; $display("FAIL ovf_data1: got %h want %h", bus.batch_data_o, e.data); end
      bus.batch_ready_i = 1;
      @(negedge clk_i);
      n_checks++; if (bus.batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovf_valid2: got %b want 1", bus.batch_valid_o); end
      e = exp_q.pop_front();
      n_checks++; if (bus.batch_cnt_o !== e.cnt) begin n_fail++; $display("FAIL ovf_cnt2: got %0d want %0d", bus.batch_cnt_o, e.cnt); end
      n_checks++; if (bus.batch_data_o !== e.data) begin n_fail++; $display("FAIL ovf_data2: got %h want %h", bus.batch_data_o, e.data); end
      @(negedge clk_i);
      n_checks++; if (bus.batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b want 0", bus.batch_valid_o); end
   endtask

   task automatic test_flush_done();
      bus.batch_ready_i = 1;
      e = '0; e.cnt = 3'd2; e.data[15:0] = 16'h0003; e.data[31:16] = 16'h0007;
      @(negedge clk_i); bus.done_i = 1; bus.res_i = 16'h0003;
      @(negedge clk_i); bus.res_i = 16'h0007; bus.flush_i = 1;
      exp_q.push_back(e);
      @(negedge clk_i); bus.done_i = 0; bus.flush_i = 0;
      n_checks++; if (bus.batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL fd_valid: got %b want 1", bus.batch_valid_o); end
      e = exp_q.pop_front();
      n_checks++; if (bus.batch_cnt_o !== e.cnt) begin n_fail++; $display("FAIL fd_cnt: got %0d want %0d", bus.batch_cnt_o, e.cnt); end
      for (int k = 0; k < int'(e.cnt); k++) begin
         n_checks++; if (bus.batch_data_o[k*16 +: 16] !== e.data[k*16 +: 16]) begin n_fail++; $display("FAIL fd_entry%0d: got %h want %h", k, bus.batch_data_o[k*16 +: 16], e.data[k*16 +: 16]); end
      end
      @(negedge clk_i);
      n_checks++; if (bus.batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL fd_after_hs: got %b want 0", bus.batch_valid_o); end
   endtask

   task automatic test_reset_mid();
      bus.batch_ready_i = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_i); bus.done_i = 1; bus.res_i = 16'h00F0 + 16'(i);
      end
      @(negedge clk_i); bus.done_i = 0;
      n_checks++; if (bus.batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", bus.batch_valid_o); end
      reset_i = 0;
      #1;
      n_checks++; if (bus.batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.batch_valid_o); end
      n_checks++; if (bus.batch_cnt_o !== 3'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", bus.batch_cnt_o); end
      n_checks++; if (bus.drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL mid_rst_drop: got %0d want 0", bus.drop_cnt_o); end
      @(negedge clk_i); reset_i = 1;
      @(negedge clk_i);
      n_checks++; if (bus.batch_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b want 0", bus.batch_valid_o); end
      bus.batch_ready_i = 1;
      e = '0; e.cnt = 3'd4;
      for (int i = 0; i < 4; i++) begin
         bus.done_i = 1; bus.res_i = 16'h0021 + 16'(i);
         e.data[i*16 +: 16] = 16'h0021 + 16'(i);
         @(negedge clk_i);
      end
      exp_q.push_back(e);
      bus.done_i = 0;
      n_checks++; if (bus.batch_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_new_valid: got %b want 1", bus.batch_valid_o); end
      e = exp_q.pop_front();
      n_checks++; if (bus.batch_cnt_o !== e.cnt) begin n_fail++; $display("FAIL mid_new_cnt: got %0d want %0d", bus.batch_cnt_o, e.cnt); end
      n_checks++; if (bus.batch_data_o !== e.data) begin n_fail++; $display("FAIL mid_new_data: got %h want %h", bus.batch_data_o, e.data); end
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_full_batch();
      test_flush();
      test_overflow();
      test_flush_done();
      test_reset_mid();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
